ccd_dmem_loader: RTL and testbench
==================================

# ccd_dmem_loader

Capture-side loader feeding DMEM port B. After the CPU raises `ccd_en`, it waits for a start-of-frame pixel and accepts one frame of 8-bit pixels from the camera stream. It packs every 32 pixels into a 256-bit word, writes the words to consecutive DMEM addresses, then holds `ccd_done` until the CPU drops `ccd_en`. Its outputs connect directly to the `ccd_dmem_addr/data/wren` and `ccd_done` nets of the CPU/DMEM top level.

## Interface
Parameters:
- `PIX_W`, 8: pixel width.
- `WORD_W`, 256: DMEM port-B word width; must be a multiple of `PIX_W`.
- `ADDR_W`, 7: DMEM port-B address width.
- `NUM_PIXELS`, 784: pixels per frame (28x28).
- `BASE_ADDR`, 0: first DMEM word written. `BASE_ADDR + NUM_WORDS - 1` must be below `2**ADDR_W`; this is checked at elaboration.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ccd_en`  in  1  CPU request level.
- `pix_data`  in  `PIX_W`  pixel value.
- `pix_valid`  in  1  pixel beat valid.
- `frame_start`  in  1  qualifies the first pixel of a frame; meaningful only with `pix_valid`.
- `pix_ready`  out  1  beat accepted when `pix_valid & pix_ready`.
- `ccd_dmem_addr`  out  `ADDR_W`  write address.
- `ccd_dmem_data`  out  `WORD_W`  write data.
- `ccd_dmem_wren`  out  1  single-cycle write strobe.
- `ccd_done`  out  1  frame fully committed to DMEM.

## Operation
- Derived constants:
  - `PIX_PER_WORD = WORD_W/PIX_W` (32).
  - `NUM_WORDS = ceil(NUM_PIXELS/PIX_PER_WORD)` (25).
- States: IDLE, WAIT_SOF, CAPTURE, LAST_WR, DONE.
- IDLE:
  - `pix_ready=1`; beats are drained and discarded.
  - `ccd_en=1` → WAIT_SOF.
- WAIT_SOF:
  - `pix_ready=1`; beats without `frame_start` are discarded.
  - An accepted beat with `frame_start=1` becomes pixel 0 → CAPTURE.
- CAPTURE:
  - `pix_ready=1`.
  - Each accepted pixel is placed at bits `[PIX_W*k +: PIX_W]`, where k = pixel index mod 32. Pixel 0 occupies the LSBs.
  - When the 32nd pixel of a word is accepted, the word and the address `BASE_ADDR + word_idx` are registered. `ccd_dmem_wren=1` on the next cycle. The pack register clears and `word_idx` increments.
  - When pixel `NUM_PIXELS-1` is accepted → LAST_WR. The final word is written even if partially filled; unfilled bytes are zero (784 = 24·32 + 16, so word 24 has its upper 16 bytes zero).
  - A `frame_start` beat in CAPTURE restarts the frame: pixel count and `word_idx` reset to 0, the partial word is discarded, and the beat becomes pixel 0. Words already written are not rewritten.
- LAST_WR: `pix_ready=0`, `wren=1` for the final word → DONE.
- DONE:
  - `pix_ready=0`, `ccd_done=1`.
  - `ccd_en=0` → IDLE.
- Abort: `ccd_en=0` in WAIT_SOF, CAPTURE or LAST_WR → IDLE. A write registered on the previous edge still issues; no later writes occur; `ccd_done` never asserts.
- `ccd_dmem_data` and `ccd_dmem_addr` hold their last written values when `wren=0`.

## Timing
- Reset values (asynchronous):
  - State IDLE, so `pix_ready=1`.
  - `ccd_dmem_wren=0`, `ccd_dmem_addr=0`, `ccd_dmem_data=0`, `ccd_done=0`.
  - Pack register, pixel count and `word_idx` are all 0.
- Latencies:
  - `ccd_en` high at an edge in IDLE → WAIT_SOF after that edge. The first beat can be accepted in the next cycle.
  - Write latency is 1 cycle from acceptance of the completing pixel.
- Full-rate frame (`pix_valid` held high), pixel 0 accepted at cycle T:
  - Word n is written at cycle T+32n+32 (n = 0..23).
  - Pixel 783 is accepted at T+783; the final write occurs at T+784 (LAST_WR).
  - `ccd_done=1` from T+785.
- Handshake: `ccd_done` falls the cycle after `ccd_en` is sampled low. A new `ccd_en` high is honoured only from IDLE.
- Bubbles: `pix_valid` gaps stall packing without penalty. No throughput limit; at most one write per cycle.

## Structure
- Package `ccd_pkg`:
  - State enum `ccd_state_t`.
  - `PIX_PER_WORD` and `NUM_WORDS` as functions of the parameters.
- Sub-module `ccd_pixel_packer`:
  - Pack register, 5-bit lane counter, clear and load controls.
  - Flags `word_full` and `word_out`.
- The FSM, pixel/word counters and output registers live in `ccd_dmem_loader`.

## Test plan
- Basic frame: reset, `ccd_en=1`, 784 beats with value = index mod 256 and `frame_start` on the first beat. Required response:
  - 25 writes at addresses 0..24.
  - addr 0 data = bytes 0x00..0x1F, LSB first.
  - addr 24 low 16 bytes = 0x00..0x0F, upper bytes 0.
  - `ccd_done` at T+785.
- Pre-SOF junk: 10 beats without `frame_start`, then a frame. Junk is dropped, and addr 0 byte 0 equals the first `frame_start` pixel.
- Random `pix_valid` gaps (~50% duty): write contents and addresses are identical to the basic frame, and there is exactly one `wren` per word.
- Abort: drop `ccd_en` after 100 pixels:
  - Exactly 3 writes (addr 0..2), the third at most one cycle after the drop.
  - FSM returns to IDLE; `ccd_done` stays 0.
  - A new `ccd_en` captures a full frame correctly.
- Mid-frame restart: `frame_start` on pixel 40 of a frame:
  - Addr 0 is written once from the first 32 pixels.
  - The restarted frame is then written from addr 0 (rewriting it).
  - Total of 26 writes.
- Reset mid-capture: assert `rst_n=0` in CAPTURE. All outputs return to reset values immediately, and no write occurs after reset.

Source files
------------

// File: rtl/ccd_dmem_loader_pkg.sv
// ccd_pkg: shared types and derived sizes for the camera-to-DMEM loader.
//   ccd_state_t  - loader FSM states
//   pix_per_word - pixels packed into one DMEM word
//   num_words    - DMEM words per frame (last word may be partial)
package ccd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_LAST_WR  = 3'd3,
        ST_DONE     = 3'd4
    } ccd_state_t;

    function automatic int pix_per_word(input int word_w, input int pix_w);
        return word_w / pix_w;
    endfunction

    function automatic int num_words(input int num_pixels, input int ppw);
        return (num_pixels + ppw - 1) / ppw;
    endfunction

endpackage

// File: rtl/ccd_dmem_loader_if.sv
// ccd_dmem_loader_if: pixel stream in, DMEM port-B write bus out.
//   pix_data/pix_valid/frame_start : camera beat (driven by the environment)
//   pix_ready                      : loader accepts the beat
//   ccd_dmem_addr/data/wren        : DMEM port-B write (driven by the loader)
// Modports: master = loader side, slave = camera/DMEM side.
interface ccd_dmem_loader_if #(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 256,
    parameter int ADDR_W = 7
) ();

    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              frame_start;
    logic              pix_ready;
    logic [ADDR_W-1:0] ccd_dmem_addr;
    logic [WORD_W-1:0] ccd_dmem_data;
    logic              ccd_dmem_wren;

    modport master (
        input  pix_data, pix_valid, frame_start,
        output pix_ready, ccd_dmem_addr, ccd_dmem_data, ccd_dmem_wren
    );

    modport slave (
        output pix_data, pix_valid, frame_start,
        input  pix_ready, ccd_dmem_addr, ccd_dmem_data, ccd_dmem_wren
    );

endinterface

// File: rtl/ccd_pixel_packer.sv
// ccd_pixel_packer: packs pixels LSB-first into a WORD_W-bit word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : a pixel is accepted this cycle
//   clear_i      : discard the partial word; with load_i the pixel lands in lane 0
//   flush_i      : with load_i, emit the word even if not full (last pixel of frame)
//   pix_i        : pixel value
//   word_o       : packed word including the pixel being loaded this cycle
//   word_full_o  : this load fills the last lane
//   word_out_o   : word_o must be written this cycle (full or flushed)
module ccd_pixel_packer
    import ccd_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              flush_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o,
    output logic              word_out_o
);

    localparam int PPW    = pix_per_word(WORD_W, PIX_W);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [WORD_W-1:0] pack_q, pack_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LANE_W-1:0] lane_eff;

    always_comb begin
        // A clear in the same cycle as a load restarts the word at lane 0.
        lane_eff = clear_i ? '0 : lane_q;
        word_o   = clear_i ? '0 : pack_q;
        word_o[lane_eff*PIX_W +: PIX_W] = pix_i;

        word_full_o = load_i && (lane_eff == LANE_W'(PPW - 1));
        word_out_o  = load_i && (word_full_o || flush_i);

        pack_d = pack_q;
        lane_d = lane_q;
        if (load_i) begin
            if (word_out_o) begin
                // Emitted words leave zeros behind so a partial final word
                // carries zeros in its unfilled lanes.
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = word_o;
                lane_d = lane_eff + LANE_W'(1);
            end
        end else if (clear_i) begin
            pack_d = '0;
            lane_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            lane_q <= '0;
        end else begin
            pack_q <= pack_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/ccd_dmem_loader.sv
// ccd_dmem_loader: captures one camera frame into consecutive DMEM words.
//   clk, rst_n : clock, asynchronous active-low reset
//   ccd_en     : CPU request level; dropping it aborts or acknowledges done
//   bus        : pixel stream in, DMEM port-B write out (master modport)
//   ccd_done   : frame fully committed; held until ccd_en falls
module ccd_dmem_loader
    import ccd_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int WORD_W     = 256,
    parameter int ADDR_W     = 7,
    parameter int NUM_PIXELS = 784,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ccd_en,
    ccd_dmem_loader_if.master bus,
    output logic              ccd_done
);

    localparam int PPW       = pix_per_word(WORD_W, PIX_W);
    localparam int NUM_WORDS = num_words(NUM_PIXELS, PPW);
    localparam int CNT_W     = $clog2(NUM_PIXELS + 1);

    if (WORD_W % PIX_W != 0) begin : g_bad_word_w
        $error("ccd_dmem_loader: WORD_W must be a multiple of PIX_W");
    end
    if (BASE_ADDR + NUM_WORDS - 1 >= (1 << ADDR_W)) begin : g_bad_base
        $error("ccd_dmem_loader: frame does not fit in the DMEM address range");
    end

    ccd_state_t        state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d, cnt_eff;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d, widx_eff;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;

    logic              ready, accept;
    logic              sof_load, cap_load, load, restart, last;
    logic [WORD_W-1:0] packed_word;
    logic              word_full, word_out;

    assign ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_SOF) ||
                   (state_q == ST_CAPTURE);
    assign accept = bus.pix_valid && ready;

    // Pixels are only taken while ccd_en is still high, so an abort never
    // registers a new write on the cycle it is seen.
    assign sof_load = (state_q == ST_WAIT_SOF) && ccd_en && accept && bus.frame_start;
    assign cap_load = (state_q == ST_CAPTURE) && ccd_en && accept;
    assign load     = sof_load || cap_load;
    assign restart  = sof_load || (cap_load && bus.frame_start);
    assign cnt_eff  = restart ? '0 : pix_cnt_q;
    assign widx_eff = restart ? '0 : word_idx_q;
    assign last     = load && (cnt_eff == CNT_W'(NUM_PIXELS - 1));

    ccd_pixel_packer #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .clear_i     (restart || (state_q == ST_IDLE)),
        .flush_i     (last),
        .pix_i       (bus.pix_data),
        .word_o      (packed_word),
        .word_full_o (word_full),
        .word_out_o  (word_out)
    );

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;

        if (load) begin
            pix_cnt_d  = cnt_eff + CNT_W'(1);
            word_idx_d = word_full ? widx_eff + ADDR_W'(1) : widx_eff;
        end
        if (word_out) begin
            addr_d = ADDR_W'(BASE_ADDR) + widx_eff;
            data_d = packed_word;
            wren_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                pix_cnt_d  = '0;
                word_idx_d = '0;
                if (ccd_en) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!ccd_en)       state_d = ST_IDLE;
                else if (sof_load) state_d = last ? ST_LAST_WR : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!ccd_en)   state_d = ST_IDLE;
                else if (last) state_d = ST_LAST_WR;
            end
            // The final write was registered on entry; it issues this cycle.
            ST_LAST_WR: state_d = ccd_en ? ST_DONE : ST_IDLE;
            ST_DONE: begin
                if (!ccd_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
        end
    end

    assign bus.pix_ready     = ready;
    assign bus.ccd_dmem_addr = addr_q;
    assign bus.ccd_dmem_data = data_q;
    assign bus.ccd_dmem_wren = wren_q;
    assign ccd_done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_ccd_dmem_loader.sv
// tb_ccd_dmem_loader: randomized bench for ccd_dmem_loader. A queue-based
// frame model turns the list of in-frame beats into the expected DMEM writes.
module tb_ccd_dmem_loader;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 256;
    localparam int ADDR_W = 7;
    localparam int NPIX   = 784;
    localparam int BASE   = 0;
    localparam int PPW    = WORD_W / PIX_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ccd_en = 1'b0;
    logic ccd_done;

    ccd_dmem_loader_if #(.PIX_W(PIX_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    ccd_dmem_loader #(
        .PIX_W(PIX_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .NUM_PIXELS(NPIX), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ccd_en(ccd_en), .bus(bus), .ccd_done(ccd_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PIX_W-1:0] d;
        logic             sof;
        int               cyc;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        int                cyc;
    } wr_t;

    beat_t beats[$];
    wr_t   act_q[$];
    wr_t   exp_q[$];
    wr_t   mon_w;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [WORD_W-1:0] got,
                       input logic [WORD_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled half a cycle after the registering edge.
    always @(negedge clk) begin
        if (bus.ccd_dmem_wren === 1'b1) begin
            mon_w.addr = bus.ccd_dmem_addr;
            mon_w.data = bus.ccd_dmem_data;
            mon_w.cyc  = cyc;
            act_q.push_back(mon_w);
        end
    end

    // Reference: every frame_start begins a new pixel list; every 32nd pixel
    // and the frame's final pixel produce a write one cycle after acceptance.
    task automatic build_expected();
        logic [PIX_W-1:0] pix[$];
        bit started  = 1'b0;
        bit finished = 1'b0;
        wr_t w;
        int n, w0;
        exp_q.delete();
        foreach (beats[i]) begin
            if (finished) break;
            if (beats[i].sof) begin
                pix.delete();
                started = 1'b1;
            end
            if (!started) continue;
            pix.push_back(beats[i].d);
            n = pix.size();
            if ((n % PPW == 0) || (n == NPIX)) begin
                w0     = ((n - 1) / PPW) * PPW;
                w.addr = ADDR_W'(BASE + (n - 1) / PPW);
                w.data = '0;
                for (int j = w0; j < n; j++) w.data[(j - w0)*PIX_W +: PIX_W] = pix[j];
                w.cyc  = beats[i].cyc + 1;
                exp_q.push_back(w);
                if (n == NPIX) finished = 1'b1;
            end
        end
    endtask

    task automatic compare(input string tag);
        build_expected();
        chk({tag, ".nwr"}, WORD_W'(act_q.size()), WORD_W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), WORD_W'(act_q[i].addr), WORD_W'(exp_q[i].addr));
            chk($sformatf("%s.data%0d", tag, i), act_q[i].data, exp_q[i].data);
            chk($sformatf("%s.cyc%0d", tag, i), WORD_W'(act_q[i].cyc), WORD_W'(exp_q[i].cyc));
        end
    endtask

    task automatic idle(input int n);
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Enter and leave at a falling edge; rec marks beats the loader should see in-frame.
    task automatic beat(input logic [PIX_W-1:0] d, input logic sof, input bit rec);
        beat_t b;
        bus.pix_valid   = 1'b1;
        bus.pix_data    = d;
        bus.frame_start = sof;
        if (rec) begin
            b.d = d; b.sof = sof; b.cyc = cyc;
            beats.push_back(b);
        end
        @(negedge clk);
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit idx_vals, input int gap_pct, input int sof_at);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (k < 4 && $urandom_range(99) < gap_pct) begin
                idle(1);
                k++;
            end
            beat(idx_vals ? PIX_W'(i) : PIX_W'($urandom), (i == 0) || (i == sof_at), 1'b1);
        end
    endtask

    task automatic start();
        beats.delete();
        act_q.delete();
        ccd_en = 1'b1;
        @(negedge clk);
    endtask

    // Called in the cycle after the frame's last beat (the final-write cycle).
    task automatic finish_frame(input string tag);
        int last_cyc;
        last_cyc = beats[beats.size()-1].cyc;
        chk({tag, ".lastwr_wren"}, WORD_W'(bus.ccd_dmem_wren), WORD_W'(1));
        chk({tag, ".lastwr_ready"}, WORD_W'(bus.pix_ready), WORD_W'(0));
        chk({tag, ".lastwr_done"}, WORD_W'(ccd_done), WORD_W'(0));
        @(negedge clk);
        chk({tag, ".done"}, WORD_W'(ccd_done), WORD_W'(1));
        chk({tag, ".done_cyc"}, WORD_W'(cyc), WORD_W'(last_cyc + 2));
        chk({tag, ".done_ready"}, WORD_W'(bus.pix_ready), WORD_W'(0));
        ccd_en = 1'b0;
        @(negedge clk);
        chk({tag, ".done_fall"}, WORD_W'(ccd_done), WORD_W'(0));
        chk({tag, ".idle_ready"}, WORD_W'(bus.pix_ready), WORD_W'(1));
        compare(tag);
    endtask

    logic [WORD_W-1:0] ref_w;

    initial begin
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst.ready", WORD_W'(bus.pix_ready), WORD_W'(1));
        chk("rst.wren", WORD_W'(bus.ccd_dmem_wren), WORD_W'(0));
        chk("rst.addr", WORD_W'(bus.ccd_dmem_addr), WORD_W'(0));
        chk("rst.data", bus.ccd_dmem_data, '0);
        chk("rst.done", WORD_W'(ccd_done), WORD_W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Beats while disabled are drained, even one carrying frame_start.
        for (int i = 0; i < 5; i++) beat(PIX_W'($urandom), i == 2, 1'b0);
        idle(3);
        chk("idle.nwr", WORD_W'(act_q.size()), WORD_W'(0));

        // Basic frame, pixel value = index mod 256.
        start();
        send_frame(NPIX, 1'b1, 0, -1);
        finish_frame("basic");
        for (int j = 0; j < PPW; j++) ref_w[j*PIX_W +: PIX_W] = PIX_W'(j);
        chk("basic.word0", act_q[0].data, ref_w);
        ref_w = '0;
        for (int j = 0; j < 16; j++) ref_w[j*PIX_W +: PIX_W] = PIX_W'(768 + j);
        chk("basic.word24", act_q[24].data, ref_w);
        chk("basic.addr24", WORD_W'(act_q[24].addr), WORD_W'(24));

        // Junk before the first frame_start.
        start();
        for (int i = 0; i < 10; i++) beat(PIX_W'($urandom), 1'b0, 1'b1);
        send_frame(NPIX, 1'b0, 0, -1);
        finish_frame("junk");
        chk("junk.byte0", WORD_W'(act_q[0].data[PIX_W-1:0]), WORD_W'(beats[10].d));

        // Random valid gaps, same content as the basic frame.
        start();
        send_frame(NPIX, 1'b1, 50, -1);
        finish_frame("gap");

        // Aborts: after 100 pixels, and exactly as the third word completes.
        for (int a = 0; a < 2; a++) begin
            start();
            send_frame((a == 0) ? 100 : 96, 1'b0, 0, -1);
            ccd_en = 1'b0;
            for (int i = 0; i < 4; i++) beat(PIX_W'($urandom), i == 1, 1'b0);
            idle(40);
            chk($sformatf("abort%0d.done", a), WORD_W'(ccd_done), WORD_W'(0));
            chk($sformatf("abort%0d.ready", a), WORD_W'(bus.pix_ready), WORD_W'(1));
            compare($sformatf("abort%0d", a));
            chk($sformatf("abort%0d.n3", a), WORD_W'(act_q.size()), WORD_W'(3));
            start();
            send_frame(NPIX, 1'b0, 0, -1);
            finish_frame($sformatf("after_abort%0d", a));
        end

        // Mid-frame restart at pixel 40.
        start();
        send_frame(NPIX + 40, 1'b0, 0, 40);
        finish_frame("restart");
        chk("restart.n26", WORD_W'(act_q.size()), WORD_W'(26));

        // Reset while capturing (word 1 already written).
        start();
        send_frame(70, 1'b0, 0, -1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = PIX_W'($urandom);
        #2 rst_n = 1'b0;
        #1;
        chk("rstcap.wren", WORD_W'(bus.ccd_dmem_wren), WORD_W'(0));
        chk("rstcap.addr", WORD_W'(bus.ccd_dmem_addr), WORD_W'(0));
        chk("rstcap.data", bus.ccd_dmem_data, '0);
        chk("rstcap.done", WORD_W'(ccd_done), WORD_W'(0));
        chk("rstcap.ready", WORD_W'(bus.pix_ready), WORD_W'(1));
        act_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) beat(PIX_W'($urandom), 1'b0, 1'b0);
        idle(3);
        chk("rstcap.nwr", WORD_W'(act_q.size()), WORD_W'(0));
        ccd_en = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
